// File: rtl/breakout_pkg.sv
// Shared breakout types and playfield geometry, used by the paddle and ball stages.
package breakout_pkg;

  typedef enum logic [1:0] {
    SERVE  = 2'd0,
    FLIGHT = 2'd1,
    OVER   = 2'd2
  } state_t;

  localparam logic [9:0]        SCREEN_W  = 10'd640;
  localparam logic [9:0]        SCREEN_H  = 10'd480;
  localparam logic [9:0]        BALL_SIZE = 10'd8;
  localparam logic [9:0]        PADDLE_W  = 10'd64;
  localparam logic [9:0]        PADDLE_Y  = 10'd440;
  localparam logic signed [3:0] SPEED     = 4'sd2;
  localparam logic [1:0]        LIVES     = 2'd3;

  function automatic logic signed [3:0] abs4(input logic signed [3:0] v);
    logic signed [3:0] r;
    if (v < 4'sd0) begin
      r = -v;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/ball_collide.sv
// Combinational next-position/velocity for one flight step with wall, paddle and miss checks.
// Optional macro BALL_ANGLE_EN: paddle hit zone selects the horizontal speed.
module ball_collide
  import breakout_pkg::*;
(
  input  logic [9:0]        ball_x,
  input  logic [9:0]        ball_y,
  input  logic signed [3:0] dx,
  input  logic signed [3:0] dy,
  input  logic [9:0]        paddle_x,
  output logic [9:0]        next_x,
  output logic [9:0]        next_y,
  output logic signed [3:0] next_dx,
  output logic signed [3:0] next_dy,
  output logic              hit_left,
  output logic              hit_right,
  output logic              hit_top,
  output logic              hit_paddle,
  output logic              hit_miss
);

  localparam logic signed [11:0] X_MAX = $signed({2'b00, SCREEN_W - BALL_SIZE});
  localparam logic signed [11:0] Y_MAX = $signed({2'b00, SCREEN_H - BALL_SIZE});
  localparam logic signed [11:0] PAD_Y = $signed({2'b00, PADDLE_Y});
  localparam logic signed [11:0] PAD_W = $signed({2'b00, PADDLE_W});
  localparam logic signed [11:0] SIZE  = $signed({2'b00, BALL_SIZE});
`ifdef BALL_ANGLE_EN
  localparam logic signed [11:0] HALF  = $signed({2'b00, BALL_SIZE >> 4'd1});
  localparam logic signed [11:0] QUART = $signed({2'b00, PADDLE_W >> 4'd2});
  logic signed [11:0] zone_s;
`endif

  logic signed [11:0] bx_s, by_s, px_s, nx_s, ny_s;
  logic signed [3:0]  mag_x_s;

  // One flight step evaluated in 12-bit signed space so negative overshoot is visible.
  always_comb begin
    bx_s = $signed({2'b00, ball_x});
    by_s = $signed({2'b00, ball_y});
    px_s = $signed({2'b00, paddle_x});
    nx_s = bx_s + $signed({{8{dx[3]}}, dx});
    ny_s = by_s + $signed({{8{dy[3]}}, dy});

    hit_left   = (nx_s < 12'sd0);
    hit_right  = (nx_s > X_MAX);
    hit_top    = (ny_s < 12'sd0);
    hit_paddle = !hit_top && (dy > 4'sd0) && ((by_s + SIZE) <= PAD_Y) &&
                 ((ny_s + SIZE) > PAD_Y) && ((nx_s + SIZE) > px_s) && (nx_s < (px_s + PAD_W));
    hit_miss   = !hit_top && !hit_paddle && (ny_s > Y_MAX);

    mag_x_s = abs4(dx);
`ifdef BALL_ANGLE_EN
    zone_s = bx_s + HALF - px_s;
    if (hit_paddle) begin
      if ((zone_s < QUART) || (zone_s >= (PAD_W - QUART))) begin
        mag_x_s = SPEED + SPEED;
      end else begin
        mag_x_s = SPEED;
      end
    end else begin
      mag_x_s = abs4(dx);
    end
`endif

    if (hit_left) begin
      next_x  = 10'd0;
      next_dx = mag_x_s;
    end else if (hit_right) begin
      next_x  = X_MAX[9:0];
      next_dx = -mag_x_s;
    end else begin
      next_x  = nx_s[9:0];
      next_dx = dx[3] ? -mag_x_s : mag_x_s;
    end

    if (hit_top) begin
      next_y  = 10'd0;
      next_dy = abs4(dy);
    end else if (hit_paddle) begin
      next_y  = (PAD_Y - SIZE);
      next_dy = -abs4(dy);
    end else begin
      next_y  = ny_s[9:0];
      next_dy = dy;
    end
  end

endmodule

// File: rtl/ball_motion.sv
// Ball FSM (serve/flight/over), lives counter and registered position outputs.
// Optional macro BALL_ANGLE_EN is consumed by ball_collide.
module ball_motion
  import breakout_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       pause,
  input  logic       launch,
  input  logic [9:0] paddle_x,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       miss,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       in_play
);

  localparam logic [9:0] SERVE_OFF = (PADDLE_W >> 4'd1) - (BALL_SIZE >> 4'd1);
  localparam logic [9:0] SERVE_Y   = PADDLE_Y - BALL_SIZE;

  state_t            state_r, state_s;
  logic [9:0]        ball_x_r, ball_x_s, ball_y_r, ball_y_s, serve_x_s;
  logic signed [3:0] dx_r, dx_s, dy_r, dy_s;
  logic [1:0]        lives_r, lives_s;
  logic              miss_r, miss_s, game_over_r, game_over_s, in_play_r, in_play_s;

  logic [9:0]        col_x_s, col_y_s;
  logic signed [3:0] col_dx_s, col_dy_s;
  logic              hit_left_s, hit_right_s, hit_top_s, hit_paddle_s, hit_miss_s;

  ball_collide u_collide (
    .ball_x     (ball_x_r),
    .ball_y     (ball_y_r),
    .dx         (dx_r),
    .dy         (dy_r),
    .paddle_x   (paddle_x),
    .next_x     (col_x_s),
    .next_y     (col_y_s),
    .next_dx    (col_dx_s),
    .next_dy    (col_dy_s),
    .hit_left   (hit_left_s),
    .hit_right  (hit_right_s),
    .hit_top    (hit_top_s),
    .hit_paddle (hit_paddle_s),
    .hit_miss   (hit_miss_s)
  );

  // Next-state and next-output logic; everything holds unless an unpaused tick arrives.
  always_comb begin
    state_s   = state_r;
    ball_x_s  = ball_x_r;
    ball_y_s  = ball_y_r;
    dx_s      = dx_r;
    dy_s      = dy_r;
    lives_s   = lives_r;
    miss_s    = 1'b0;
    serve_x_s = paddle_x + SERVE_OFF;
    if (tick && !pause) begin
      case (state_r)
        SERVE: begin
          ball_x_s = serve_x_s;
          ball_y_s = SERVE_Y;
          if (launch) begin
            state_s = FLIGHT;
            dx_s    = SPEED;
            dy_s    = -SPEED;
          end else begin
            state_s = SERVE;
          end
        end
        FLIGHT: begin
          ball_x_s = col_x_s;
          ball_y_s = col_y_s;
          if (hit_left_s || hit_right_s || hit_top_s || hit_paddle_s) begin
            dx_s = col_dx_s;
            dy_s = col_dy_s;
          end else begin
            dx_s = dx_r;
            dy_s = dy_r;
          end
          if (hit_miss_s) begin
            miss_s = 1'b1;
            if (lives_r <= 2'd1) begin
              lives_s = 2'd0;
              state_s = OVER;
            end else begin
              lives_s = lives_r - 2'd1;
              state_s = SERVE;
            end
          end else begin
            state_s = FLIGHT;
          end
        end
        OVER: begin
          state_s = OVER;
        end
        default: begin
          state_s = SERVE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
    game_over_s = (state_s == OVER);
    in_play_s   = (state_s == FLIGHT);
  end

  // State and output registers with synchronous reset overriding all inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= SERVE;
      ball_x_r    <= paddle_x + SERVE_OFF;
      ball_y_r    <= SERVE_Y;
      dx_r        <= SPEED;
      dy_r        <= -SPEED;
      lives_r     <= LIVES;
      miss_r      <= 1'b0;
      game_over_r <= 1'b0;
      in_play_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      ball_x_r    <= ball_x_s;
      ball_y_r    <= ball_y_s;
      dx_r        <= dx_s;
      dy_r        <= dy_s;
      lives_r     <= lives_s;
      miss_r      <= miss_s;
      game_over_r <= game_over_s;
      in_play_r   <= in_play_s;
    end
  end

  assign ball_x    = ball_x_r;
  assign ball_y    = ball_y_r;
  assign miss      = miss_r;
  assign lives     = lives_r;
  assign game_over = game_over_r;
  assign in_play   = in_play_r;

endmodule
